wb_line_master: RTL and testbench
=================================

Name: wb_line_master

Overview:
- Wishbone master that moves one cache-line-sized block of LINE_WORDS words between an internal line buffer and a Wishbone slave. Typical slave: the on-chip RAM or the memory controller.
- Uses incrementing linear bursts: CTI 3'b010, BTE 2'b00, all byte lanes selected.
- Sits between a cache or DMA client and the system bus. The client loads or unloads the line buffer through a simple port, then issues one command.

Parameters:
- WB_ADDR_BITS, 32, Wishbone address width.
- WORD_BYTES, 4, bytes per word; WORD_BITS = 8*WORD_BYTES.
- LINE_WORDS, 8, words per line; must be a power of two, at least 2.
- BURST_CTI, 3'b010, CTI driven on non-final beats.
- BURST_BTE, 2'b00, BTE driven on every beat.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with WB_TIMEOUT_EN.

Ports:
- wbm_clk_i  in  1  single clock.
- wbm_rst_i  in  1  synchronous, active-high reset.
- cmd_stb  in  1  command request; sampled only in IDLE.
- cmd_we  in  1  1 = write line to bus, 0 = read line from bus.
- cmd_addr  in  WB_ADDR_BITS-2  word address [WB_ADDR_BITS-1:2]; the low log2(LINE_WORDS) bits are forced to 0.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle pulse at end of a transfer.
- err  out  1  valid with done; 1 = transfer aborted.
- buf_we  in  1  client write strobe to line buffer.
- buf_addr  in  log2(LINE_WORDS)  client buffer index.
- buf_din  in  WORD_BITS  client write data.
- buf_dout  out  WORD_BITS  buffer[buf_addr], combinational read.
- wbm_cyc_o, wbm_stb_o  out  1  bus cycle / strobe.
- wbm_addr_o  out  WB_ADDR_BITS-2  word address [WB_ADDR_BITS-1:2].
- wbm_cti_o  out  3 / wbm_bte_o  out  2  burst tags.
- wbm_sel_o  out  WORD_BYTES  always all ones.
- wbm_we_o  out  1  bus write enable.
- wbm_data_o  out  WORD_BITS  write data.
- wbm_data_i  in  WORD_BITS  read data.
- wbm_ack_i, wbm_err_i  in  1  slave ack / error.

Behaviour:
- Reset values: cyc, stb, we, busy, done and err are 0. Addr is 0, cti is 3'b000, data_o is 0. bte = BURST_BTE and sel = all ones at all times. The buffer contents are not reset.
- States:
  - IDLE:
    - When cmd_stb = 1, latch cmd_we and the aligned address, clear the beat counter, set busy, and go to BUS.
    - Cyc and stb assert on the next cycle, i.e. first bus edge = accept edge + 1.
  - BUS:
    - Hold cyc = stb = 1, wbm_we_o = latched we, wbm_addr_o = base + beat.
    - wbm_cti_o = BURST_CTI while beat < LINE_WORDS-1, and 3'b111 on the final beat.
    - wbm_data_o = buffer[beat].
    - On each wbm_ack_i:
      - Reads capture wbm_data_i into buffer[beat].
      - Beat increments, and the address and data for the next beat are presented the following cycle.
    - Back-to-back acks are supported with no bubble, giving LINE_WORDS cycles minimum in BUS.
    - On ack of the final beat: drop cyc/stb the next cycle, pulse done with err = 0, then go to IDLE.
    - On wbm_err_i (ack ignored that cycle): drop cyc/stb, pulse done with err = 1, go to IDLE. The buffer keeps the words captured so far.
  - Done/busy: busy falls in the same cycle done pulses. A new cmd_stb is accepted in the cycle after done.
- Ignored inputs:
  - cmd_stb while busy is ignored; it is not queued.
  - buf_we while busy is ignored.
  - buf_dout remains readable at all times.
- Simultaneous events:
  - ack and err in the same cycle: err wins.
  - buf_we in the IDLE cycle where cmd_stb is accepted: the write completes before the transfer starts.
- Wrap: the beat counter is log2(LINE_WORDS)+1 bits. The address never crosses the line boundary because of the forced alignment.
- Reset mid-burst: at the reset edge cyc/stb go to 0 and the state returns to IDLE; no done pulse is produced.
- Full-line latency with a zero-wait slave: cmd accept to done = LINE_WORDS + 2 cycles.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on every ack and on entry to BUS, and increments each BUS cycle without ack or err.
  - When it reaches TIMEOUT_CYCLES, abort exactly as for wbm_err_i (done with err = 1).
- Without the macro: no counter exists and BUS waits indefinitely for ack or err.

Test Plan:
- Write line: load buffer words 0..7 with 32'h1000_0000+i, cmd_we = 1, cmd_addr = 30'h0000_0104 (aligned to 0x100).
  - Addr sequence 0x100..0x107; cti = 010 ×7 then 111; slave RAM then holds the values.
  - done at cycle 10 after accept, err = 0.
- Read line: preload the slave with 32'hA5A5_0000+i, cmd_we = 0, addr 0x200 → buf_dout[i] = 32'hA5A5_0000+i after done.
- Wait states: slave inserts 2 idle cycles before beat 3 → address and data held steady during the wait; done at cycle 12 after accept.
- Bus error: slave asserts err on beat 5 of a read → cyc drops the next cycle; done and err = 1; buffer words 0..4 updated, words 5..7 unchanged.
- Ignored inputs and reset mid-burst:
  - cmd_stb and buf_we during BUS → no effect on the transfer or the buffer.
  - Assert wbm_rst_i at beat 3 → cyc = 0 at the next edge, no done pulse, and the next command works normally.
- With WB_TIMEOUT_EN and TIMEOUT_CYCLES = 16: slave never acks → done with err = 1 after 16 BUS cycles.

Source files
------------

// File: rtl/wb_line_master.sv
`default_nettype none
// ============================================================================
// wb_line_master
// Wishbone burst master that moves one LINE_WORDS line between a local
// buffer and a slave. Optional macro WB_TIMEOUT_EN adds an ack watchdog.
// Revision: 1.0
// ============================================================================

module wb_line_master #(
  parameter int         WB_ADDR_BITS   = 32,
  parameter int         WORD_BYTES     = 4,
  parameter int         LINE_WORDS     = 8,
  parameter logic [2:0] BURST_CTI      = 3'b010,
  parameter logic [1:0] BURST_BTE      = 2'b00,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic                            wbm_clk_i,
  input  logic                            wbm_rst_i,
  input  logic                            cmd_stb,
  input  logic                            cmd_we,
  input  logic [WB_ADDR_BITS-3:0]         cmd_addr,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  input  logic                            buf_we,
  input  logic [$clog2(LINE_WORDS)-1:0]   buf_addr,
  input  logic [8*WORD_BYTES-1:0]         buf_din,
  output logic [8*WORD_BYTES-1:0]         buf_dout,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  output logic [WB_ADDR_BITS-3:0]         wbm_addr_o,
  output logic [2:0]                      wbm_cti_o,
  output logic [1:0]                      wbm_bte_o,
  output logic [WORD_BYTES-1:0]           wbm_sel_o,
  output logic                            wbm_we_o,
  output logic [8*WORD_BYTES-1:0]         wbm_data_o,
  input  logic [8*WORD_BYTES-1:0]         wbm_data_i,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i
);

  localparam int WORD_BITS = 8 * WORD_BYTES;
  localparam int LW_BITS   = $clog2(LINE_WORDS);
  localparam int WA_BITS   = WB_ADDR_BITS - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 we_q, we_d;
  logic [WA_BITS-1:0]   base_q, base_d;
  logic [LW_BITS:0]     beat_q, beat_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 abort_q, abort_d;

  logic [WORD_BITS-1:0] mem_q [LINE_WORDS];
  logic                 mem_we;
  logic [LW_BITS-1:0]   mem_wa;
  logic [WORD_BITS-1:0] mem_wd;

  logic                 in_bus;
  logic                 last_beat;

  assign in_bus    = (state_q == S_BUS);
  assign last_beat = (beat_q == (LW_BITS+1)'(LINE_WORDS - 1));

`ifdef WB_TIMEOUT_EN
  localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_BITS-1:0] to_q, to_d;

  always_ff @(posedge wbm_clk_i) begin
    if (wbm_rst_i) to_q <= '0;
    else           to_q <= to_d;
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    base_d  = base_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    abort_d = abort_q;
    mem_we  = 1'b0;
    mem_wa  = buf_addr;
    mem_wd  = buf_din;
`ifdef WB_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Client write lands on the same edge that accepts a command, so the
        // burst always sees it.
        mem_we = buf_we;
        if (cmd_stb && !done_q) begin
          state_d = S_BUS;
          we_d    = cmd_we;
          base_d  = cmd_addr & ~WA_BITS'(LINE_WORDS - 1);
          beat_d  = '0;
          abort_d = 1'b0;
`ifdef WB_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      S_BUS: begin
        if (wbm_err_i) begin
          state_d = S_FIN;
          abort_d = 1'b1;
        end else if (wbm_ack_i) begin
          if (!we_q) begin
            mem_we = 1'b1;
            mem_wa = beat_q[LW_BITS-1:0];
            mem_wd = wbm_data_i;
          end
          beat_d = beat_q + (LW_BITS+1)'(1);
          if (last_beat) state_d = S_FIN;
`ifdef WB_TIMEOUT_EN
          to_d   = '0;
`endif
        end
`ifdef WB_TIMEOUT_EN
        else if (to_q == TO_BITS'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_FIN;
          abort_d = 1'b1;
        end else begin
          to_d = to_q + TO_BITS'(1);
        end
`endif
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        err_d   = abort_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wbm_clk_i) begin
    if (wbm_rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  // Buffer contents survive reset; only the write on a reset edge is blocked.
  always_ff @(posedge wbm_clk_i) begin
    if (mem_we && !wbm_rst_i) mem_q[mem_wa] <= mem_wd;
  end

  assign buf_dout   = mem_q[buf_addr];
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign wbm_cyc_o  = in_bus;
  assign wbm_stb_o  = in_bus;
  assign wbm_we_o   = in_bus & we_q;
  assign wbm_addr_o = in_bus ? (base_q | WA_BITS'(beat_q[LW_BITS-1:0])) : '0;
  assign wbm_cti_o  = in_bus ? (last_beat ? 3'b111 : BURST_CTI) : 3'b000;
  assign wbm_bte_o  = BURST_BTE;
  assign wbm_sel_o  = '1;
  assign wbm_data_o = in_bus ? mem_q[beat_q[LW_BITS-1:0]] : '0;

endmodule

`default_nettype wire

// File: tb/tb_wb_line_master.sv
`default_nettype none
// ============================================================================
// tb_wb_line_master
// Directed plus randomized checks of wb_line_master against a line-level
// model and a behavioural Wishbone slave.
// Revision: 1.0
// ============================================================================

module tb_wb_line_master;

  localparam int LW = 8;
  localparam int TO = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_stb, cmd_we;
  logic [29:0] cmd_addr;
  logic        busy, done, err;
  logic        buf_we;
  logic [2:0]  buf_addr;
  logic [31:0] buf_din, buf_dout;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [29:0] wbm_addr_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_data_o, wbm_data_i;
  logic        wbm_ack_i, wbm_err_i;

  wb_line_master #(
    .WB_ADDR_BITS(32), .WORD_BYTES(4), .LINE_WORDS(LW),
    .BURST_CTI(3'b010), .BURST_BTE(2'b00), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wbm_clk_i(clk), .wbm_rst_i(rst),
    .cmd_stb(cmd_stb), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .busy(busy), .done(done), .err(err),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_din(buf_din), .buf_dout(buf_dout),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_addr_o(wbm_addr_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_data_o(wbm_data_o), .wbm_data_i(wbm_data_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Line-level reference model, advanced on each rising edge from the inputs.
  bit          m_act, m_wrap, m_done, m_err, m_abort, m_we;
  logic [29:0] m_base;
  int          m_beat, m_to;
  logic [31:0] m_buf [LW];
  bit          m_bv  [LW];

  initial begin
    bit pd;
    m_act = 0; m_wrap = 0; m_done = 0; m_err = 0; m_abort = 0; m_we = 0;
    m_base = '0; m_beat = 0; m_to = 0;
    for (int i = 0; i < LW; i++) m_bv[i] = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_act = 0; m_wrap = 0; m_done = 0; m_err = 0;
      end else begin
        pd = m_done;
        m_done = 0; m_err = 0;
        if (m_wrap) begin
          m_wrap = 0; m_done = 1; m_err = m_abort;
        end else if (m_act) begin
          if (wbm_err_i) begin
            m_act = 0; m_wrap = 1; m_abort = 1;
          end else if (wbm_ack_i) begin
            if (!m_we) begin m_buf[m_beat] = wbm_data_i; m_bv[m_beat] = 1; end
            m_beat++;
            m_to = 0;
            if (m_beat == LW) begin m_act = 0; m_wrap = 1; m_abort = 0; end
          end else begin
`ifdef WB_TIMEOUT_EN
            m_to++;
            if (m_to == TO) begin m_act = 0; m_wrap = 1; m_abort = 1; end
`endif
          end
        end else begin
          if (buf_we) begin m_buf[buf_addr] = buf_din; m_bv[buf_addr] = 1; end
          if (cmd_stb && !pd) begin
            m_act = 1; m_we = cmd_we; m_beat = 0; m_to = 0;
            m_base = cmd_addr & ~30'(LW - 1);
          end
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    logic [29:0] ea;
    forever begin
      @(negedge clk); #1;
      if (chk_en) begin
        ea = m_act ? 30'(m_base + 30'(m_beat)) : 30'h0;
        chk("cyc", wbm_cyc_o, m_act);
        chk("stb", wbm_stb_o, m_act);
        chk("we", wbm_we_o, m_act & m_we);
        chk("addr", wbm_addr_o, ea);
        chk("cti", wbm_cti_o, !m_act ? 3'b000 : (m_beat == LW - 1 ? 3'b111 : 3'b010));
        if (!m_act) chk("data_o", wbm_data_o, 0);
        else if (m_bv[m_beat]) chk("data_o", wbm_data_o, m_buf[m_beat]);
        chk("busy", busy, m_act | m_wrap);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("sel", wbm_sel_o, 4'hF);
        chk("bte", wbm_bte_o, 2'b00);
        if (m_bv[buf_addr]) chk("buf_dout", buf_dout, m_buf[buf_addr]);
      end
    end
  end

  // Behavioural Wishbone slave with configurable wait/error injection.
  logic [31:0] slv_mem [int];
  logic [29:0] lg_addr [$];
  logic [2:0]  lg_cti  [$];
  int sl_wait_beat = -1, sl_wait_n = 0, sl_err_beat = -1;
  bit sl_rand = 0, sl_hang = 0;

  initial begin
    int b, a, sl_wait;
    bit prev_cyc, prev_ack;
    wbm_ack_i = 0; wbm_err_i = 0; wbm_data_i = '0;
    sl_wait = 0; prev_cyc = 0; prev_ack = 0;
    forever begin
      @(negedge clk);
      if (wbm_cyc_o && wbm_stb_o) begin
        b = int'(wbm_addr_o[2:0]);
        a = int'(wbm_addr_o);
        if (!prev_cyc || prev_ack) begin
          if (sl_rand) sl_wait = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
          else         sl_wait = (b == sl_wait_beat) ? sl_wait_n : 0;
        end
        wbm_ack_i = 0; wbm_err_i = 0;
        if (sl_hang) begin
        end else if (sl_wait > 0) begin
          sl_wait--;
        end else if (sl_rand) begin
          if ($urandom_range(0, 19) == 0) begin
            wbm_err_i = 1; wbm_ack_i = 1'($urandom_range(0, 1));
          end else wbm_ack_i = 1;
        end else if (b == sl_err_beat) wbm_err_i = 1;
        else wbm_ack_i = 1;
        if (!slv_mem.exists(a)) slv_mem[a] = $urandom;
        wbm_data_i = wbm_we_o ? $urandom : slv_mem[a];
        prev_ack = wbm_ack_i && !wbm_err_i;
        if (prev_ack) begin
          if (wbm_we_o) slv_mem[a] = wbm_data_o;
          lg_addr.push_back(wbm_addr_o);
          lg_cti.push_back(wbm_cti_o);
        end
      end else begin
        wbm_ack_i = 0; wbm_err_i = 0; prev_ack = 0;
        wbm_data_i = $urandom;
      end
      prev_cyc = wbm_cyc_o;
    end
  end

  task automatic load_buf(input logic [31:0] base_v, input bit rnd);
    for (int i = 0; i < LW; i++) begin
      @(negedge clk);
      buf_we = 1; buf_addr = 3'(i);
      buf_din = rnd ? $urandom : base_v + 32'(i);
    end
    @(negedge clk);
    buf_we = 0;
  endtask

  task automatic run_cmd(input bit we, input logic [29:0] addr, input bit noise,
                         output int lat, output bit e);
    lg_addr.delete(); lg_cti.delete();
    @(negedge clk);
    cmd_stb = 1; cmd_we = we; cmd_addr = addr;
    @(negedge clk);
    cmd_stb = 0; buf_we = 0; lat = 1;
    while (done !== 1'b1 && lat < 400) begin
      if (noise && wbm_cyc_o) begin
        cmd_stb = 1'($urandom); cmd_we = 1'($urandom); cmd_addr = 30'($urandom);
        buf_we = 1'($urandom); buf_addr = 3'($urandom); buf_din = $urandom;
      end else begin
        cmd_stb = 0; buf_we = 0;
      end
      @(negedge clk);
      lat++;
    end
    cmd_stb = 0; buf_we = 0;
    chk("done_seen", done, 1);
    e = err;
  endtask

  task automatic chk_buf(input int i, input logic [31:0] exp);
    @(negedge clk);
    buf_addr = 3'(i);
    #1;
    chk("buf_word", buf_dout, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    int lat, nd;
    bit e;
    rst = 1; cmd_stb = 0; cmd_we = 0; cmd_addr = '0;
    buf_we = 0; buf_addr = '0; buf_din = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", wbm_addr_o, 0);
    chk("rst_cti", wbm_cti_o, 0);
    chk("rst_data", wbm_data_o, 0);
    chk("rst_sel", wbm_sel_o, 4'hF);
    rst = 0;
    chk_en = 1;

    // Write line to 0x100 (command address 0x104 is aligned down).
    load_buf(32'h1000_0000, 0);
    run_cmd(1, 30'h104, 0, lat, e);
    chk("wr_latency", lat, 10);
    chk("wr_err", e, 0);
    chk("wr_beats", lg_addr.size(), 8);
    for (int i = 0; i < LW && i < lg_addr.size(); i++) begin
      chk("wr_addr_seq", lg_addr[i], 30'h100 + 30'(i));
      chk("wr_cti_seq", lg_cti[i], (i == LW - 1) ? 3'b111 : 3'b010);
    end
    for (int i = 0; i < LW; i++) chk("wr_slave_mem", slv_mem[32'h100 + i], 32'h1000_0000 + 32'(i));

    // Read line from 0x200.
    for (int i = 0; i < LW; i++) slv_mem[32'h200 + i] = 32'hA5A5_0000 + 32'(i);
    run_cmd(0, 30'h200, 0, lat, e);
    chk("rd_latency", lat, 10);
    chk("rd_err", e, 0);
    for (int i = 0; i < LW; i++) chk_buf(i, 32'hA5A5_0000 + 32'(i));

    // Two wait states before beat 3.
    sl_wait_beat = 3; sl_wait_n = 2;
    run_cmd(0, 30'h20B, 0, lat, e);
    chk("wait_latency", lat, 12);
    chk("wait_err", e, 0);
    sl_wait_beat = -1; sl_wait_n = 0;

    // Bus error on beat 5 of a read.
    load_buf(32'hDEAD_0000, 0);
    for (int i = 0; i < LW; i++) slv_mem[32'h300 + i] = 32'h5A5A_0000 + 32'(i);
    sl_err_beat = 5;
    run_cmd(0, 30'h300, 0, lat, e);
    chk("berr_latency", lat, 8);
    chk("berr_err", e, 1);
    sl_err_beat = -1;
    for (int i = 0; i < 5; i++) chk_buf(i, 32'h5A5A_0000 + 32'(i));
    for (int i = 5; i < LW; i++) chk_buf(i, 32'hDEAD_0000 + 32'(i));

    // cmd_stb and buf_we noise during a write burst.
    load_buf(32'h7700_0000, 0);
    run_cmd(1, 30'h600, 1, lat, e);
    chk("noise_latency", lat, 10);
    chk("noise_err", e, 0);
    for (int i = 0; i < LW; i++) chk("noise_slave_mem", slv_mem[32'h600 + i], 32'h7700_0000 + 32'(i));
    for (int i = 0; i < LW; i++) chk_buf(i, 32'h7700_0000 + 32'(i));

    // Reset while beat 3 is on the bus.
    for (int i = 0; i < LW; i++) slv_mem[32'h700 + i] = 32'h3300_0000 + 32'(i);
    @(negedge clk);
    cmd_stb = 1; cmd_we = 0; cmd_addr = 30'h700;
    @(negedge clk);
    cmd_stb = 0;
    repeat (3) @(negedge clk);
    chk("mid_addr_beat3", wbm_addr_o, 30'h703);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_cyc", wbm_cyc_o, 0);
    chk("mid_rst_busy", busy, 0);
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_rst_no_done", nd, 0);
    run_cmd(0, 30'h700, 0, lat, e);
    chk("post_rst_latency", lat, 10);
    chk("post_rst_err", e, 0);
    for (int i = 0; i < LW; i++) chk_buf(i, 32'h3300_0000 + 32'(i));

`ifdef WB_TIMEOUT_EN
    sl_hang = 1;
    run_cmd(0, 30'h500, 0, lat, e);
    chk("timeout_latency", lat, TO + 2);
    chk("timeout_err", e, 1);
    sl_hang = 0;
`endif

    // Randomized transactions with random waits, errors and noise.
    sl_rand = 1;
    repeat (40) begin
      if ($urandom_range(0, 1) == 1) load_buf(32'h0, 1);
      run_cmd(1'($urandom), 30'($urandom), 1'($urandom), lat, e);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    sl_rand = 0;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
